// File: rtl/mips_pkg.sv
// Shared MIPS-I definitions: opcode/funct codes, ALU operation codes and the
// layout of the 16-bit control word shown on the LEDs.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Field order fixes the LED bit positions: reg_write is bit 0, alu_op is [15:12].
  typedef struct packed {
    alu_op_e    alu_op;
    logic       ext_zero;
    logic       link;
    logic       jump_reg;
    logic       jump;
    logic       branch_ne;
    logic       branch;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_r2000_alu.sv
// 32-bit integer ALU; shifts take the amount from a_i and the value from b_i.
module alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = 32'h0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {31'h0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'h0, a_i < b_i};
      ALU_SLL:  result_o = b_i << a_i[4:0];
      ALU_SRL:  result_o = b_i >> a_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      ALU_LUI:  result_o = {b_i[15:0], 16'h0};
      default:  result_o = 32'h0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/mips_r2000_dmem.sv
// Word-addressed data memory, asynchronous read, synchronous write, cleared by reset.
module DataMemory #(
  parameter int WORDS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     we_i,
  input  logic [$clog2(WORDS)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] DataMemory [WORDS];

  // Storage array with full clear on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < WORDS; i++) DataMemory[i] <= 32'h0;
    end else if (we_i) begin
      DataMemory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = DataMemory[addr_i];

endmodule

// File: rtl/mips_r2000_gpr.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write.
module GPR (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] gprRegisters [32];

  // Register array; $0 is never written so it stays zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) gprRegisters[i] <= 32'h0;
    end else if (we_i && (wa_i != 5'd0)) begin
      gprRegisters[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : gprRegisters[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : gprRegisters[ra2_i];

endmodule

// File: rtl/mips_r2000_imem.sv
// Read-only instruction store, filled externally before the core leaves reset.
module InstructionMemory #(
  parameter int WORDS = 1024
) (
  input  logic [$clog2(WORDS)-1:0] addr_i,
  output logic [31:0]              instr_o
);

  logic [31:0] IMem [WORDS];

  assign instr_o = IMem[addr_i];

endmodule

// File: rtl/mips_r2000.sv
// Single-cycle MIPS-I core: one instruction retires per CLK rising edge.
// Decoder and next-PC logic live here; memories, register file and ALU are sub-blocks.
module mips_r2000
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        CLK,
  input  logic        rstn,
  output logic [15:0] CtrlSignal
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pcOut;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] gprDataIn;
  logic [31:0] gprDataOut1;
  logic [31:0] gprDataOut2;
  logic [31:0] imm_ext;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] dmem_rdata;
  logic        alu_zero;
  logic        RegWrite;
  logic        MemWrite;
  logic        shamt_shift;
  logic        branch_taken;
  logic [4:0]  wr_addr;
  ctrl_t       ctrl;
  ctrl_t       ctrl_live;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  InstructionMemory #(.WORDS(IMEM_WORDS)) U_InstructionMemory (
    .addr_i  (pcOut[IAW+1:2]),
    .instr_o (instr)
  );

  // Control decode; anything not recognised leaves the all-zero (no-write) word.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RD;
        case (funct)
          FN_ADD, FN_ADDU:          ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU:          ctrl.alu_op = ALU_SUB;
          FN_AND:                   ctrl.alu_op = ALU_AND;
          FN_OR:                    ctrl.alu_op = ALU_OR;
          FN_XOR:                   ctrl.alu_op = ALU_XOR;
          FN_NOR:                   ctrl.alu_op = ALU_NOR;
          FN_SLT:                   ctrl.alu_op = ALU_SLT;
          FN_SLTU:                  ctrl.alu_op = ALU_SLTU;
          FN_SLL, FN_SLLV:          ctrl.alu_op = ALU_SLL;
          FN_SRL, FN_SRLV:          ctrl.alu_op = ALU_SRL;
          FN_SRA, FN_SRAV:          ctrl.alu_op = ALU_SRA;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.reg_dst   = DST_RT;
            ctrl.jump_reg  = 1'b1;
          end
          FN_JALR: begin
            ctrl.jump_reg = 1'b1;
            ctrl.link     = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_SLTIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_zero  = 1'b1;
        ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                         (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (opcode == OP_BNE);
        ctrl.alu_op    = ALU_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RA;
      end
      default: ctrl = '0;
    endcase
  end

  // The all-zero word doubles as the canonical NOP, which would otherwise decode as sll $0.
  assign ctrl_live  = (rstn && (instr != 32'h0)) ? ctrl : '0;
  assign CtrlSignal = ctrl_live;
  assign RegWrite   = ctrl_live.reg_write;
  assign MemWrite   = ctrl_live.mem_write;

  GPR U_GPR (
    .clk_i   (CLK),
    .rst_n_i (rstn),
    .we_i    (RegWrite),
    .ra1_i   (rs),
    .ra2_i   (rt),
    .wa_i    (wr_addr),
    .wd_i    (gprDataIn),
    .rd1_o   (gprDataOut1),
    .rd2_o   (gprDataOut2)
  );

  assign shamt_shift = (opcode == OP_RTYPE) &&
                       ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
  assign imm_ext = ctrl_live.ext_zero ? {16'h0, imm} : sext16(imm);
  assign alu_a   = shamt_shift ? {27'h0, shamt} : gprDataOut1;
  assign alu_b   = ctrl_live.alu_src ? imm_ext : gprDataOut2;

  alu U_ALU (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (ctrl_live.alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  DataMemory #(.WORDS(DMEM_WORDS)) U_DataMemory (
    .clk_i   (CLK),
    .rst_n_i (rstn),
    .we_i    (MemWrite),
    .addr_i  (alu_result[DAW+1:2]),
    .wdata_i (gprDataOut2),
    .rdata_o (dmem_rdata)
  );

  // Destination register and write-back value selection.
  always_comb begin
    wr_addr = rt;
    case (ctrl_live.reg_dst)
      DST_RT:  wr_addr = rt;
      DST_RD:  wr_addr = rd;
      DST_RA:  wr_addr = 5'd31;
      default: wr_addr = rt;
    endcase
    if (ctrl_live.link) begin
      gprDataIn = pc_plus4;
    end else if (ctrl_live.mem_to_reg) begin
      gprDataIn = dmem_rdata;
    end else begin
      gprDataIn = alu_result;
    end
  end

  assign pc_plus4     = pcOut + 32'd4;
  assign branch_taken = ctrl_live.branch && (alu_zero ^ ctrl_live.branch_ne);

  // Next-PC selection: register jump, absolute jump, taken branch, fall-through.
  always_comb begin
    if (ctrl_live.jump_reg) begin
      pc_d = gprDataOut1;
    end else if (ctrl_live.jump) begin
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
    end else begin
      pc_d = pc_plus4;
    end
  end

  // Program counter.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      pcOut <= RESET_PC;
    end else begin
      pcOut <= pc_d;
    end
  end

endmodule

// File: tb/tb_mips_r2000.sv
// Directed bench for mips_r2000: hand-assembled programs written into the
// instruction memory, register/memory state checked against hand-computed values.
module tb_mips_r2000;

  logic        CLK = 1'b0;
  logic        rstn;
  logic [15:0] CtrlSignal;
  int          checks = 0;
  int          errors = 0;

  mips_r2000 dut (
    .CLK        (CLK),
    .rstn       (rstn),
    .CtrlSignal (CtrlSignal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_t(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.U_InstructionMemory.IMem[addr / 4] = w;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] gpr(input int n);
    return dut.U_GPR.gprRegisters[n];
  endfunction

  initial begin
    logic [31:0] acc;
    rstn = 1'b0;

    put(32'h00, i_t(6'h09, 5'd0, 5'd1, 16'd5));        // addiu $1,$0,5
    put(32'h04, i_t(6'h09, 5'd0, 5'd2, 16'hFFFD));     // addiu $2,$0,-3
    put(32'h08, r_t(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));   // addu $3,$1,$2
    put(32'h0C, r_t(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A));   // slt $4,$2,$1
    put(32'h10, i_t(6'h04, 5'd1, 5'd1, 16'd2));        // beq $1,$1,+2
    put(32'h14, i_t(6'h09, 5'd0, 5'd20, 16'd1));       // skipped
    put(32'h18, i_t(6'h09, 5'd0, 5'd20, 16'd1));       // skipped
    put(32'h1C, i_t(6'h05, 5'd1, 5'd1, 16'd2));        // bne $1,$1,+2
    put(32'h20, j_t(6'h03, 26'h10));                   // jal 0x40
    put(32'h24, r_t(5'd2, 5'd1, 5'd5, 5'd0, 6'h2B));   // sltu $5,$2,$1
    put(32'h28, i_t(6'h0F, 5'd0, 5'd6, 16'h1234));     // lui $6,0x1234
    put(32'h2C, i_t(6'h0D, 5'd6, 5'd6, 16'h5678));     // ori $6,$6,0x5678
    put(32'h30, i_t(6'h2B, 5'd0, 5'd6, 16'd8));        // sw $6,8($0)
    put(32'h34, i_t(6'h23, 5'd0, 5'd7, 16'd8));        // lw $7,8($0)
    put(32'h38, i_t(6'h09, 5'd0, 5'd0, 16'd7));        // addiu $0,$0,7
    put(32'h3C, j_t(6'h02, 26'h14));                   // j 0x50
    put(32'h40, r_t(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));  // jr $31
    put(32'h50, r_t(5'd0, 5'd2, 5'd8, 5'd1, 6'h03));   // sra $8,$2,1
    put(32'h54, i_t(6'h0C, 5'd2, 5'd9, 16'hFFFF));     // andi $9,$2,0xFFFF
    put(32'h58, r_t(5'd1, 5'd0, 5'd10, 5'd0, 6'h27));  // nor $10,$1,$0
    put(32'h5C, r_t(5'd1, 5'd1, 5'd11, 5'd0, 6'h04));  // sllv $11,$1,$1
    put(32'h60, i_t(6'h0A, 5'd2, 5'd12, 16'hFFFE));    // slti $12,$2,-2
    put(32'h64, i_t(6'h0B, 5'd1, 5'd13, 16'hFFFF));    // sltiu $13,$1,-1
    put(32'h68, {6'h3F, 26'h0});                       // unknown opcode
    put(32'h6C, j_t(6'h02, 26'h1B));                   // j 0x6C

    #12;
    chk("rst_pc", dut.pcOut, 32'h0);
    chk("rst_ctrl", {16'h0, CtrlSignal}, 32'h0);

    @(negedge CLK);
    rstn = 1'b1;
    #1;
    chk("ctrl_addiu", {16'h0, CtrlSignal}, 32'h0009);
    step();
    step();
    chk("r1", gpr(1), 32'd5);
    chk("r2", gpr(2), 32'hFFFF_FFFD);
    chk("ctrl_addu", {16'h0, CtrlSignal}, 32'h0011);
    chk("gprDataIn_addu", dut.gprDataIn, 32'd2);
    step();
    chk("r3_addu", gpr(3), 32'd2);
    step();
    chk("r4_slt", gpr(4), 32'd1);
    chk("ctrl_beq", {16'h0, CtrlSignal}, 32'h1040);
    step();
    chk("pc_beq_taken", dut.pcOut, 32'h1C);
    chk("ctrl_bne", {16'h0, CtrlSignal}, 32'h10C0);
    step();
    chk("pc_bne_not_taken", dut.pcOut, 32'h20);
    chk("r20_skipped", gpr(20), 32'h0);
    chk("ctrl_jal", {16'h0, CtrlSignal}, 32'h0521);
    step();
    chk("pc_jal", dut.pcOut, 32'h40);
    chk("r31_link", gpr(31), 32'h24);
    step();
    chk("pc_jr", dut.pcOut, 32'h24);
    step();
    chk("r5_sltu", gpr(5), 32'h0);
    step();
    step();
    chk("r6_lui_ori", gpr(6), 32'h1234_5678);
    chk("ctrl_sw", {16'h0, CtrlSignal}, 32'h000A);
    step();
    chk("dmem2_sw", dut.U_DataMemory.DataMemory[2], 32'h1234_5678);
    step();
    chk("r7_lw", gpr(7), 32'h1234_5678);
    step();
    chk("r0_write_ignored", gpr(0), 32'h0);
    step();
    chk("pc_j", dut.pcOut, 32'h50);
    step();
    chk("r8_sra", gpr(8), 32'hFFFF_FFFE);
    chk("ctrl_andi", {16'h0, CtrlSignal}, 32'h2809);
    step();
    chk("r9_andi", gpr(9), 32'h0000_FFFD);
    step();
    chk("r10_nor", gpr(10), 32'hFFFF_FFFA);
    step();
    chk("r11_sllv", gpr(11), 32'h0000_00A0);
    step();
    chk("r12_slti", gpr(12), 32'd1);
    step();
    chk("r13_sltiu", gpr(13), 32'd1);
    chk("ctrl_unknown", {16'h0, CtrlSignal}, 32'h0);
    step();
    chk("pc_unknown_nop", dut.pcOut, 32'h6C);
    step();
    chk("pc_halt_loop", dut.pcOut, 32'h6C);

    @(negedge CLK);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_pc", dut.pcOut, 32'h0);
    chk("midrst_ctrl", {16'h0, CtrlSignal}, 32'h0);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | gpr(i);
    chk("midrst_gpr", acc, 32'h0);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | dut.U_DataMemory.DataMemory[i];
    chk("midrst_dmem", acc, 32'h0);

    put(32'h00, i_t(6'h09, 5'd0, 5'd1, 16'd5));
    put(32'h04, i_t(6'h2B, 5'd0, 5'd1, 16'd0));
    put(32'h08, i_t(6'h09, 5'd0, 5'd1, 16'd3));
    put(32'h0C, i_t(6'h2B, 5'd0, 5'd1, 16'd4));
    put(32'h10, i_t(6'h09, 5'd0, 5'd1, 16'd9));
    put(32'h14, i_t(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h18, i_t(6'h09, 5'd0, 5'd1, 16'd1));
    put(32'h1C, i_t(6'h2B, 5'd0, 5'd1, 16'd12));
    put(32'h20, i_t(6'h09, 5'd0, 5'd10, 16'd3));       // passes
    put(32'h24, i_t(6'h09, 5'd0, 5'd11, 16'd0));       // outer: ptr=0
    put(32'h28, i_t(6'h09, 5'd0, 5'd12, 16'd3));       // inner count
    put(32'h2C, i_t(6'h23, 5'd11, 5'd2, 16'd0));       // inner: lw $2,0($11)
    put(32'h30, i_t(6'h23, 5'd11, 5'd3, 16'd4));       // lw $3,4($11)
    put(32'h34, r_t(5'd3, 5'd2, 5'd4, 5'd0, 6'h2A));   // slt $4,$3,$2
    put(32'h38, i_t(6'h04, 5'd4, 5'd0, 16'd2));        // beq $4,$0,noswap
    put(32'h3C, i_t(6'h2B, 5'd11, 5'd3, 16'd0));       // sw $3,0($11)
    put(32'h40, i_t(6'h2B, 5'd11, 5'd2, 16'd4));       // sw $2,4($11)
    put(32'h44, i_t(6'h09, 5'd11, 5'd11, 16'd4));      // noswap: ptr+=4
    put(32'h48, i_t(6'h09, 5'd12, 5'd12, 16'hFFFF));   // count--
    put(32'h4C, i_t(6'h05, 5'd12, 5'd0, 16'hFFF7));    // bne -> inner
    put(32'h50, i_t(6'h09, 5'd10, 5'd10, 16'hFFFF));   // passes--
    put(32'h54, i_t(6'h05, 5'd10, 5'd0, 16'hFFF3));    // bne -> outer
    put(32'h58, j_t(6'h02, 26'h16));                   // j 0x58

    @(negedge CLK);
    rstn = 1'b1;
    for (int c = 0; c < 512 && dut.pcOut != 32'h58; c++) step();
    chk("sort_reached_halt", dut.pcOut, 32'h58);
    chk("sort_d0", dut.U_DataMemory.DataMemory[0], 32'd1);
    chk("sort_d1", dut.U_DataMemory.DataMemory[1], 32'd3);
    chk("sort_d2", dut.U_DataMemory.DataMemory[2], 32'd5);
    chk("sort_d3", dut.U_DataMemory.DataMemory[3], 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
